// File: rtl/dm_resp_pkg.sv
// rtl/dm_resp_pkg.sv - shared state encoding and constants for the data-memory responder
// Contents: state_t (IDLE/WAIT/RESP), byte-enable constants, wait-counter width.
package dm_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dm_resp_ram.sv
// rtl/dm_resp_ram.sv - word array with per-lane write enables and a registered read
// Ports:
//   clk   : clock
//   we    : per-byte-lane write enable (lane i = data[8i+7:8i])
//   re    : read enable; rdata updates only when set and holds otherwise
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module dm_resp_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // No reset: array contents survive a responder reset.
  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - data-memory responder with programmable wait states
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_we/req_addr/req_be/req_wdata: store flag, byte address, lane enables, store data
//   rsp_valid/rsp_ready             : response handshake
//   rsp_rdata/rsp_err               : load data, request-rejected flag
//   busy                            : transaction in flight (state != IDLE)
module dm_resp #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_HI     = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  import dm_resp_pkg::*;

  localparam int              HI_W      = 30 - ADDR_W;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic        lat_we;
  logic [31:2] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        acc_go;
  logic        acc_we;
  logic [31:2] acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        acc_err;

  logic        rd_sel;
  logic [31:0] ram_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];
  assign accept          = (state == IDLE) && req_valid;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request; otherwise it uses the latched copy.
  always_comb begin
    acc_go    = 1'b0;
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_be    = lat_be;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_go    = req_valid && (WAIT_CYCLES == 0);
      acc_we    = req_we;
      acc_addr  = req_addr[31:2];
      acc_be    = req_be;
      acc_wdata = req_wdata;
    end else if (state == WAIT) begin
      acc_go = (cnt == CNT_W'(1));
    end
  end

  assign acc_err = (acc_addr[31:ADDR_W+2] != BASE_HI[HI_W-1:0]) || (acc_be == BE_NONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Counter, request latch and response flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= WAIT_INIT;
        lat_we    <= req_we;
        lat_addr  <= req_addr[31:2];
        lat_be    <= req_be;
        lat_wdata <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (acc_go) begin
        rsp_err <= acc_err;
        rd_sel  <= !acc_we && !acc_err;
      end
    end
  end

  // The RAM read register only loads on a good load, so rsp_rdata holds its
  // value in IDLE; stores and errors (and reset) force it to zero via rd_sel.
  assign rsp_rdata = rd_sel ? ram_rdata : 32'h0;

  dm_resp_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   ((acc_go && acc_we && !acc_err) ? acc_be : 4'b0000),
    .re   (acc_go && !acc_we && !acc_err),
    .addr (acc_addr[ADDR_W+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - self-checking bench for dm_resp (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_dm_resp;

  localparam int W_A = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk, rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        req_valid_0, req_ready_0, req_we_0, rsp_valid_0, rsp_ready_0, rsp_err_0, busy_0;
  logic [31:0] req_addr_0, req_wdata_0, rsp_rdata_0;
  logic [3:0]  req_be_0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  exp_t sbq0[$];
  vec_t tbl[12];
  vec_t s0[5];

  dm_resp #(.ADDR_W(10), .WAIT_CYCLES(W_A), .BASE_HI(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dm_resp #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_HI(32'h0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_we(req_we_0),
    .req_addr(req_addr_0), .req_be(req_be_0), .req_wdata(req_wdata_0),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0), .rsp_rdata(rsp_rdata_0),
    .rsp_err(rsp_err_0), .busy(busy_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response scoreboards: pop on every consumed response.
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: got response %h with no pending request", rsp_rdata);
      end else begin
        e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid_0 && rsp_ready_0) begin
      if (sbq0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb0_unexpected: got response %h with no pending request", rsp_rdata_0);
      end else begin
        e = sbq0.pop_front();
        check("w0_rsp_rdata", rsp_rdata_0, e.rdata);
        check("w0_rsp_err", {31'b0, rsp_err_0}, {31'b0, e.err});
      end
    end
  end

  task automatic drive(input vec_t v);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_be    = v.be;
    req_wdata = v.wdata;
  endtask

  // One complete transaction on the WAIT_CYCLES=2 instance with rsp_ready=1.
  task automatic run_txn(input vec_t v, input string tag);
    int n, lo;
    @(posedge clk); #2;
    drive(v);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    check({tag, "_accept"}, {31'b0, req_ready}, 32'd1);
    sbq.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk); #2;
    req_valid = 1'b0;
    n = 0; lo = 0;
    do begin
      @(negedge clk); n++;
      if (!req_ready) lo++;
    end while (!rsp_valid && n < 20);
    check({tag, "_latency"}, n, W_A + 1);
    check({tag, "_ready_low"}, lo, W_A + 1);
    @(negedge clk);
    check({tag, "_idle_again"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int   n, k, cyc, last_acc, guard;

    rst = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_be = 0; req_wdata = 0; rsp_ready = 1'b1;
    req_valid_0 = 0; req_we_0 = 0; req_addr_0 = 0; req_be_0 = 0; req_wdata_0 = 0; rsp_ready_0 = 1'b1;

    //          we    addr          be     wdata         exp_rdata     exp_err
    tbl[0]  = '{1'b1, 32'h0000_0014, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hAAAAAAAA, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'h11223344, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        32'hAA22AA44, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 32'h0000_1020, 4'hF, 32'h55555555, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h0000_0020, 4'h1, 32'h0,        32'hAA22AA44, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0023, 4'hF, 32'h0,        32'hAA22AA44, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0030, 4'hF, 32'h12345678, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h0000_0030, 4'hF, 32'h0,        32'h12345678, 1'b0};

    s0[0] = '{1'b1, 32'h0000_0040, 4'hF, 32'h0BADF00D, 32'h0,        1'b0};
    s0[1] = '{1'b1, 32'h0000_0044, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    s0[2] = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,        32'h0BADF00D, 1'b0};
    s0[3] = '{1'b0, 32'h0000_0044, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
    s0[4] = '{1'b0, 32'h0000_0040, 4'h2, 32'h0,        32'h0BADF00D, 1'b0};

    // Reset state
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_w0_req_ready", {31'b0, req_ready_0}, 32'd1);
    check("rst_w0_busy", {31'b0, busy_0}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // Table: load/store/lane/error cases
    for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Stalled response: outputs hold, req_valid pulses ignored
    rsp_ready = 1'b0;
    @(posedge clk); #2;
    v = '{1'b0, 32'h0000_0014, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
    drive(v);
    @(negedge clk);
    check("stall_accept", {31'b0, req_ready}, 32'd1);
    sbq.push_back('{32'hDEADBEEF, 1'b0});
    @(posedge clk); #2;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    check("stall_latency", n, W_A + 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      req_valid = (i < 3); req_we = 1'b1; req_wdata = 32'h0;
      @(negedge clk);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("stall_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #2;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_idle_ready", {31'b0, req_ready}, 32'd1);
    check("stall_idle_busy", {31'b0, busy}, 32'd0);
    check("stall_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    run_txn(v, "stall_readback");

    // Reset in the middle of WAIT of a store to 0x30
    @(posedge clk); #2;
    v = '{1'b1, 32'h0000_0030, 4'hF, 32'hFFFF0000, 32'h0, 1'b0};
    drive(v);
    @(negedge clk);
    check("rstw_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstw_busy_before", {31'b0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rstw_busy", {31'b0, busy}, 32'd0);
    check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    run_txn(tbl[11], "rstw_readback");

    // WAIT_CYCLES=0: back-to-back, rsp_ready tied high
    @(posedge clk); #2;
    req_valid_0 = 1'b1; req_we_0 = s0[0].we; req_addr_0 = s0[0].addr;
    req_be_0 = s0[0].be; req_wdata_0 = s0[0].wdata;
    k = 0; cyc = 0; last_acc = -10; guard = 0;
    while (k < 5 && guard < 60) begin
      @(negedge clk); cyc++; guard++;
      if (rsp_valid_0) check("w0_latency", cyc - last_acc, 1);
      if (req_ready_0) begin
        if (k > 0) check("w0_spacing", cyc - last_acc, 2);
        sbq0.push_back('{s0[k].exp_rdata, s0[k].exp_err});
        last_acc = cyc; k++;
        @(posedge clk); #2;
        if (k < 5) begin
          req_we_0 = s0[k].we; req_addr_0 = s0[k].addr;
          req_be_0 = s0[k].be; req_wdata_0 = s0[k].wdata;
        end else begin
          req_valid_0 = 1'b0;
        end
      end
    end
    check("w0_all_accepted", k, 5);
    @(negedge clk);
    check("w0_last_rsp_valid", {31'b0, rsp_valid_0}, 32'd1);
    repeat (2) @(negedge clk);

    check("sbq_drained", sbq.size(), 0);
    check("sbq0_drained", sbq0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
